// File: rtl/noc_vc_input_port_pkg.sv
// Shared types for the virtual-channel router input port.
// Flit metadata, VC identifiers and the packet-arbiter state encoding.
package noc_vc_input_port_pkg;

    localparam int DEFAULT_NUM_VC     = 4;
    localparam int DEFAULT_DEPTH      = 4;
    localparam int DEFAULT_FLIT_WIDTH = 64;

    typedef logic [$clog2(DEFAULT_NUM_VC)-1:0] vc_id_t;

    typedef struct packed {
        logic head;
        logic tail;
    } flit_meta_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-VC first-word-fall-through FIFO; dout always shows the oldest entry.
// Push and pop in the same cycle keep count unchanged and preserve order.
module noc_vc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/noc_vc_input_port.sv
// Router input port: demultiplexes one flit link into per-VC FIFOs and serves them
// to the switch with wormhole locking, round-robin VC choice and upstream credits.
module noc_vc_input_port
    import noc_vc_input_port_pkg::*;
#(
    parameter int NUM_VC     = DEFAULT_NUM_VC,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [$clog2(NUM_VC)-1:0] in_vc,
    input  logic [FLIT_WIDTH-1:0]     in_flit,
    input  logic                      in_head,
    input  logic                      in_tail,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NUM_VC)-1:0] out_vc,
    output logic [FLIT_WIDTH-1:0]     out_flit,
    output logic                      out_head,
    output logic                      out_tail,
    output logic                      credit_valid,
    output logic [$clog2(NUM_VC)-1:0] credit_vc,
    output logic                      overflow_err,
    output logic                      pkt_err
);

    localparam int VC_W    = $clog2(NUM_VC);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = FLIT_WIDTH + 2;

    // Arbiter state; lock_vc doubles as the held candidate while hold is set.
    typedef struct packed {
        arb_state_e      state;
        logic            hold;
        logic [VC_W-1:0] lock_vc;
        logic [VC_W-1:0] last_grant;
    } arb_t;

    arb_t arb_q;
    arb_t arb_d;

    logic [ENTRY_W-1:0] fifo_dout  [NUM_VC];
    logic [CNT_W-1:0]   fifo_count [NUM_VC];
    logic [NUM_VC-1:0]  fifo_empty;
    logic [NUM_VC-1:0]  fifo_full;
    logic [NUM_VC-1:0]  fifo_push;
    logic [NUM_VC-1:0]  fifo_pop;

    logic [VC_W-1:0]       idx;
    logic [VC_W-1:0]       cand;
    logic                  cand_found;
    logic [VC_W-1:0]       sel_vc;
    flit_meta_t            sel_meta;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic                  handshake;
    logic                  orphan;
    logic                  pop_any;
    logic                  same_vc_pop;
    logic                  wr_accept;
    logic                  overflow_set;

    genvar g;
    generate
        for (g = 0; g < NUM_VC; g++) begin : g_vc
            assign fifo_push[g] = wr_accept && (in_vc == VC_W'(g));
            assign fifo_pop[g]  = pop_any && (sel_vc == VC_W'(g));

            noc_vc_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (ENTRY_W)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (fifo_push[g]),
                .pop   (fifo_pop[g]),
                .din   ({in_head, in_tail, in_flit}),
                .dout  (fifo_dout[g]),
                .empty (fifo_empty[g]),
                .full  (fifo_full[g]),
                .count (fifo_count[g])
            );
        end
    endgenerate

    // A write to a full VC still lands if that VC frees a slot on the same edge.
    always_comb begin
        same_vc_pop  = pop_any && (sel_vc == in_vc);
        wr_accept    = in_valid && ((fifo_count[in_vc] < CNT_W'(DEPTH)) || same_vc_pop);
        overflow_set = in_valid && fifo_full[in_vc] && !same_vc_pop;
    end

    // Round-robin search starting just after last_grant, unless a stalled offer is held.
    always_comb begin
        idx        = '0;
        cand       = '0;
        cand_found = 1'b0;
        if (arb_q.hold) begin
            cand       = arb_q.lock_vc;
            cand_found = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_VC; i++) begin
                idx = arb_q.last_grant + VC_W'(i);
                if (!cand_found && !fifo_empty[idx]) begin
                    cand       = idx;
                    cand_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_vc   = (arb_q.state == LOCKED) ? arb_q.lock_vc : cand;
        sel_meta = flit_meta_t'(fifo_dout[sel_vc][ENTRY_W-1 -: 2]);
        sel_flit = fifo_dout[sel_vc][FLIT_WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arb_q <= '{state: IDLE, hold: 1'b0, lock_vc: '0, last_grant: VC_W'(NUM_VC - 1)};
        end else begin
            arb_q <= arb_d;
        end
    end

    // Next-state logic.
    always_comb begin
        arb_d      = arb_q;
        arb_d.hold = 1'b0;
        case (arb_q.state)
            IDLE: begin
                if (handshake) begin
                    arb_d.last_grant = cand;
                    arb_d.lock_vc    = cand;
                    if (!sel_meta.tail) begin
                        arb_d.state = LOCKED;
                    end
                end else if (out_valid) begin
                    arb_d.hold    = 1'b1;
                    arb_d.lock_vc = cand;
                end
            end
            LOCKED: begin
                if (handshake && sel_meta.tail) begin
                    arb_d.state = IDLE;
                end
            end
            default: arb_d.state = IDLE;
        endcase
    end

    // Output logic. Handshake: a flit moves on a clk edge with out_valid && out_ready;
    // once out_valid is high it stays high, with the same flit, until that edge.
    always_comb begin
        out_valid = 1'b0;
        orphan    = 1'b0;
        case (arb_q.state)
            IDLE: begin
                if (cand_found) begin
                    if (sel_meta.head) begin
                        out_valid = 1'b1;
                    end else begin
                        orphan = 1'b1;
                    end
                end
            end
            LOCKED:  out_valid = !fifo_empty[arb_q.lock_vc];
            default: out_valid = 1'b0;
        endcase
        out_vc    = sel_vc;
        out_flit  = sel_flit;
        out_head  = sel_meta.head;
        out_tail  = sel_meta.tail;
        handshake = out_valid && out_ready;
        pop_any   = handshake || orphan;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_valid <= 1'b0;
            credit_vc    <= '0;
            overflow_err <= 1'b0;
            pkt_err      <= 1'b0;
        end else begin
            credit_valid <= pop_any;
            credit_vc    <= sel_vc;
            if (overflow_set) begin
                overflow_err <= 1'b1;
            end
            if (orphan) begin
                pkt_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_vc_input_port.sv
// Self-checking bench for noc_vc_input_port: scenario tasks drive flits and
// compare the observed output and credit streams against expected queues.
module tb_noc_vc_input_port;

    localparam int NUM_VC = 4;
    localparam int DEPTH  = 4;
    localparam int FW     = 64;
    localparam int VC_W   = 2;
    localparam int IW     = VC_W + 2 + FW;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [VC_W-1:0] in_vc;
    logic [FW-1:0]   in_flit;
    logic            in_head;
    logic            in_tail;
    logic            out_valid;
    logic            out_ready;
    logic [VC_W-1:0] out_vc;
    logic [FW-1:0]   out_flit;
    logic            out_head;
    logic            out_tail;
    logic            credit_valid;
    logic [VC_W-1:0] credit_vc;
    logic            overflow_err;
    logic            pkt_err;

    logic [IW-1:0]   exp_q[$];
    logic [IW-1:0]   got_q[$];
    logic [VC_W-1:0] exp_cred_q[$];
    logic [VC_W-1:0] cred_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    noc_vc_input_port #(
        .NUM_VC     (NUM_VC),
        .DEPTH      (DEPTH),
        .FLIT_WIDTH (FW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_vc        (in_vc),
        .in_flit      (in_flit),
        .in_head      (in_head),
        .in_tail      (in_tail),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_vc       (out_vc),
        .out_flit     (out_flit),
        .out_head     (out_head),
        .out_tail     (out_tail),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .overflow_err (overflow_err),
        .pkt_err      (pkt_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Observation side of the scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) got_q.push_back({out_vc, out_head, out_tail, out_flit});
            if (credit_valid) cred_q.push_back(credit_vc);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [VC_W-1:0] vc, input logic [FW-1:0] f,
                        input logic h, input logic t);
        in_valid = 1'b1;
        in_vc    = vc;
        in_flit  = f;
        in_head  = h;
        in_tail  = t;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        exp_cred_q.delete();
        cred_q.delete();
    endtask

    task automatic wait_outputs();
        for (int c = 0; c < 80 && (got_q.size() < exp_q.size() || cred_q.size() < exp_cred_q.size()); c++)
            tick();
        tick();
        tick();
    endtask

    // Scenario tasks
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (credit_valid !== 1'b0) $display("FAIL reset_credit_valid: got %b want 0", credit_valid);
        else n_pass++;
        n_checks++;
        if (overflow_err !== 1'b0) $display("FAIL reset_overflow_err: got %b want 0", overflow_err);
        else n_pass++;
        n_checks++;
        if (pkt_err !== 1'b0) $display("FAIL reset_pkt_err: got %b want 0", pkt_err);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [VC_W-1:0] rr_vc [3] = '{2'd0, 2'd1, 2'd3};
        logic [FW-1:0]   f;
        logic [IW-1:0]   e, g;
        logic [VC_W-1:0] ce, cg;
        out_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                f = 64'h100 + 64'(r * 16 + k);
                send(rr_vc[k], f, 1'b1, 1'b1);
                exp_q.push_back({rr_vc[k], 1'b1, 1'b1, f});
                exp_cred_q.push_back(rr_vc[k]);
            end
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_vc !== 2'd0)
            $display("FAIL rr_stalled_offer: got valid=%b vc=%0d want valid=1 vc=0", out_valid, out_vc);
        else n_pass++;
        out_ready = 1'b1;
        wait_outputs();
        n_checks++;
        if (got_q.size() != exp_q.size() || cred_q.size() != exp_cred_q.size())
            $display("FAIL rr_count: got %0d flits %0d credits want %0d flits %0d credits",
                     got_q.size(), cred_q.size(), exp_q.size(), exp_cred_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL rr_flit: got %h want %h", g, e);
            else n_pass++;
        end
        while (exp_cred_q.size() > 0 && cred_q.size() > 0) begin
            ce = exp_cred_q.pop_front();
            cg = cred_q.pop_front();
            n_checks++;
            if (cg !== ce) $display("FAIL rr_credit_vc: got %0d want %0d", cg, ce);
            else n_pass++;
        end
        exp_q.delete(); got_q.delete(); exp_cred_q.delete(); cred_q.delete();
    endtask

    task automatic test_single();
        logic [IW-1:0]   e, g;
        out_ready = 1'b1;
        send(2'd2, 64'hA5, 1'b1, 1'b1);
        exp_q.push_back({2'd2, 1'b1, 1'b1, 64'hA5});
        exp_cred_q.push_back(2'd2);
        n_checks++;
        if (out_valid !== 1'b1 || out_vc !== 2'd2 || out_flit !== 64'hA5)
            $display("FAIL single_offer: got valid=%b vc=%0d flit=%h want valid=1 vc=2 flit=a5",
                     out_valid, out_vc, out_flit);
        else n_pass++;
        tick();
        n_checks++;
        if (credit_valid !== 1'b1 || credit_vc !== 2'd2)
            $display("FAIL single_credit: got valid=%b vc=%0d want valid=1 vc=2", credit_valid, credit_vc);
        else n_pass++;
        wait_outputs();
        n_checks++;
        if (got_q.size() != 1 || cred_q.size() != 1)
            $display("FAIL single_count: got %0d flits %0d credits want 1 flit 1 credit",
                     got_q.size(), cred_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL single_flit: got %h want %h", g, e);
            else n_pass++;
        end
        exp_q.delete(); got_q.delete(); exp_cred_q.delete(); cred_q.delete();
    endtask

    task automatic test_wormhole();
        logic [IW-1:0]   e, g;
        logic [VC_W-1:0] ce, cg;
        out_ready = 1'b1;
        send(2'd0, 64'h10, 1'b1, 1'b0);
        exp_q.push_back({2'd0, 1'b1, 1'b0, 64'h10});
        send(2'd1, 64'h20, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL worm_bubble0: got valid=%b want 0", out_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL worm_bubble1: got valid=%b want 0", out_valid);
        else n_pass++;
        send(2'd0, 64'h11, 1'b0, 1'b0);
        exp_q.push_back({2'd0, 1'b0, 1'b0, 64'h11});
        send(2'd0, 64'h12, 1'b0, 1'b1);
        exp_q.push_back({2'd0, 1'b0, 1'b1, 64'h12});
        exp_q.push_back({2'd1, 1'b1, 1'b1, 64'h20});
        exp_cred_q.push_back(2'd0);
        exp_cred_q.push_back(2'd0);
        exp_cred_q.push_back(2'd0);
        exp_cred_q.push_back(2'd1);
        wait_outputs();
        n_checks++;
        if (got_q.size() != exp_q.size() || cred_q.size() != exp_cred_q.size())
            $display("FAIL worm_count: got %0d flits %0d credits want %0d flits %0d credits",
                     got_q.size(), cred_q.size(), exp_q.size(), exp_cred_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL worm_flit: got %h want %h", g, e);
            else n_pass++;
        end
        while (exp_cred_q.size() > 0 && cred_q.size() > 0) begin
            ce = exp_cred_q.pop_front();
            cg = cred_q.pop_front();
            n_checks++;
            if (cg !== ce) $display("FAIL worm_credit_vc: got %0d want %0d", cg, ce);
            else n_pass++;
        end
        exp_q.delete(); got_q.delete(); exp_cred_q.delete(); cred_q.delete();
    endtask

    task automatic test_full();
        logic [IW-1:0] e, g;
        logic [FW-1:0] f;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            f = 64'h30 + 64'(k);
            send(2'd1, f, 1'b1, 1'b1);
            if (k < DEPTH) exp_q.push_back({2'd1, 1'b1, 1'b1, f});
        end
        n_checks++;
        if (overflow_err !== 1'b1) $display("FAIL full_overflow_set: got %b want 1", overflow_err);
        else n_pass++;
        out_ready = 1'b1;
        wait_outputs();
        n_checks++;
        if (got_q.size() != DEPTH || cred_q.size() != DEPTH)
            $display("FAIL full_drain_count: got %0d flits %0d credits want 4 and 4",
                     got_q.size(), cred_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL full_drain_flit: got %h want %h", g, e);
            else n_pass++;
        end
        // Second pass: the fifth write coincides with a pop of the same VC.
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            f = 64'h40 + 64'(k);
            if (k == 4) out_ready = 1'b1;
            send(2'd1, f, 1'b1, 1'b1);
            exp_q.push_back({2'd1, 1'b1, 1'b1, f});
        end
        n_checks++;
        if (overflow_err !== 1'b0) $display("FAIL full_same_cycle_pop: overflow got %b want 0", overflow_err);
        else n_pass++;
        wait_outputs();
        n_checks++;
        if (got_q.size() != 5 || cred_q.size() != 5)
            $display("FAIL full_pop_drain_count: got %0d flits %0d credits want 5 and 5",
                     got_q.size(), cred_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL full_pop_flit: got %h want %h", g, e);
            else n_pass++;
        end
        exp_q.delete(); got_q.delete(); exp_cred_q.delete(); cred_q.delete();
    endtask

    task automatic test_orphan();
        logic [VC_W-1:0] ce, cg;
        out_ready = 1'b1;
        send(2'd3, 64'h55, 1'b0, 1'b1);
        exp_cred_q.push_back(2'd3);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL orphan_no_offer: got valid=%b want 0", out_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (pkt_err !== 1'b1 || credit_valid !== 1'b1 || credit_vc !== 2'd3)
            $display("FAIL orphan_discard: got pkt_err=%b credit=%b vc=%0d want 1 1 3",
                     pkt_err, credit_valid, credit_vc);
        else n_pass++;
        wait_outputs();
        n_checks++;
        if (got_q.size() != 0 || cred_q.size() != 1)
            $display("FAIL orphan_count: got %0d flits %0d credits want 0 and 1",
                     got_q.size(), cred_q.size());
        else n_pass++;
        while (exp_cred_q.size() > 0 && cred_q.size() > 0) begin
            ce = exp_cred_q.pop_front();
            cg = cred_q.pop_front();
            n_checks++;
            if (cg !== ce) $display("FAIL orphan_credit_vc: got %0d want %0d", cg, ce);
            else n_pass++;
        end
        exp_q.delete(); got_q.delete(); exp_cred_q.delete(); cred_q.delete();
    endtask

    task automatic test_reset_mid_packet();
        logic [IW-1:0] e, g;
        out_ready = 1'b1;
        send(2'd2, 64'h60, 1'b1, 1'b0);
        exp_q.push_back({2'd2, 1'b1, 1'b0, 64'h60});
        tick();
        tick();
        out_ready = 1'b0;
        send(2'd2, 64'h61, 1'b0, 1'b0);
        send(2'd2, 64'h62, 1'b0, 1'b1);
        n_checks++;
        if (got_q.size() != 1 || cred_q.size() != 1 || out_valid !== 1'b1)
            $display("FAIL midrst_pre: got %0d flits %0d credits valid=%b want 1 1 1",
                     got_q.size(), cred_q.size(), out_valid);
        else n_pass++;
        if (got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL midrst_head_flit: got %h want %h", g, e);
            else n_pass++;
        end
        exp_q.delete(); got_q.delete(); exp_cred_q.delete(); cred_q.delete();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (out_valid !== 1'b0 || credit_valid !== 1'b0)
                $display("FAIL midrst_quiet: cycle %0d got valid=%b credit=%b want 0 0",
                         c, out_valid, credit_valid);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (got_q.size() != 0 || cred_q.size() != 0)
            $display("FAIL midrst_no_traffic: got %0d flits %0d credits want 0 and 0",
                     got_q.size(), cred_q.size());
        else n_pass++;
        send(2'd1, 64'h70, 1'b1, 1'b1);
        exp_q.push_back({2'd1, 1'b1, 1'b1, 64'h70});
        exp_cred_q.push_back(2'd1);
        wait_outputs();
        n_checks++;
        if (got_q.size() != 1 || cred_q.size() != 1)
            $display("FAIL midrst_after_count: got %0d flits %0d credits want 1 and 1",
                     got_q.size(), cred_q.size());
        else n_pass++;
        if (got_q.size() > 0 && cred_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e || cred_q[0] !== exp_cred_q[0])
                $display("FAIL midrst_after_flit: got %h credit %0d want %h credit %0d",
                         g, cred_q[0], e, exp_cred_q[0]);
            else n_pass++;
        end
        exp_q.delete(); got_q.delete(); exp_cred_q.delete(); cred_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vc     = '0;
        in_flit   = '0;
        in_head   = 1'b0;
        in_tail   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_wormhole();
        test_full();
        test_orphan();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
